// File: rtl/fd_pipe_reg.sv
// F/D pipeline register with stall (hold), flush (bubble) and branch-delay-slot tracking.
// Optional performance counters are built when FD_PERF_CNT_EN is defined.
module fd_pipe_reg #(
    parameter logic [31:0] FLUSH_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Flush,
    input  logic             BranchD,
    input  logic [31:0]      InstrFD,
    input  logic [31:0]      PC4FD,
    input  logic [31:0]      PCFD,
    input  logic [4:0]       ExcCodeFD,
    output logic [31:0]      InstrD,
    output logic [31:0]      PC4D,
    output logic [31:0]      PCD,
    output logic [4:0]       ExcCodeD,
    output logic             BDD,
    output logic             ValidD,
    output logic             HeldD,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        load;

    assign load = En && !Flush;

    // Flush beats stall so an interrupt or eret never waits on a hazard.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (Flush) begin
            state_d = ST_EMPTY;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            pc_d    = FLUSH_PC;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
        end else if (En) begin
            state_d = ST_FULL;
            instr_d = InstrFD;
            pc4_d   = PC4FD;
            pc_d    = PCFD;
            exc_d   = ExcCodeFD;
            bd_d    = BranchD;
        end else if (state_q != ST_EMPTY) begin
            state_d = ST_HELD;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            pc_q    <= FLUSH_PC;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign InstrD   = instr_q;
    assign PC4D     = pc4_q;
    assign PCD      = pc_q;
    assign ExcCodeD = exc_q;
    assign BDD      = bd_q;
    assign ValidD   = (state_q != ST_EMPTY);
    assign HeldD    = (state_q == ST_HELD);

`ifdef FD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Bubble cycles are counted by the state D will hold after this edge.
    always_comb begin
        instr_cnt_d  = load ? instr_cnt_q + CNT_ONE : instr_cnt_q;
        bubble_cnt_d = (state_d == ST_EMPTY) ? bubble_cnt_q + CNT_ONE : bubble_cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign InstrCnt  = instr_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`else
    logic unused_load;
    assign unused_load = load;
    assign InstrCnt    = '0;
    assign BubbleCnt   = '0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: directed scenarios plus randomized traffic
// compared every cycle against a rule-level model of the F/D register.
module tb_fd_pipe_reg;

    localparam logic [31:0] FPC   = 32'hBFC0_0380;
    localparam int          CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             En = 1'b0;
    logic             Flush = 1'b0;
    logic             BranchD = 1'b0;
    logic [31:0]      InstrFD = 32'h0;
    logic [31:0]      PC4FD = 32'h0;
    logic [31:0]      PCFD = 32'h0;
    logic [4:0]       ExcCodeFD = 5'd0;
    logic [31:0]      InstrD, PC4D, PCD;
    logic [4:0]       ExcCodeD;
    logic             BDD, ValidD, HeldD;
    logic [CNT_W-1:0] InstrCnt, BubbleCnt;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    fd_pipe_reg #(.FLUSH_PC(FPC), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Flush(Flush), .BranchD(BranchD),
        .InstrFD(InstrFD), .PC4FD(PC4FD), .PCFD(PCFD), .ExcCodeFD(ExcCodeFD),
        .InstrD(InstrD), .PC4D(PC4D), .PCD(PCD), .ExcCodeD(ExcCodeD),
        .BDD(BDD), .ValidD(ValidD), .HeldD(HeldD),
        .InstrCnt(InstrCnt), .BubbleCnt(BubbleCnt)
    );

    always #5 Clk = ~Clk;

    // Reference model: what D must contain, from the load/hold/flush rules.
    logic [31:0]      m_instr, m_pc4, m_pc;
    logic [4:0]       m_exc;
    logic             m_bd, m_valid, m_held;
    logic [CNT_W-1:0] m_icnt, m_bcnt;

    always @(posedge Clk) begin
        if (Reset) begin
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_pc <= FPC; m_exc <= 5'd0;
            m_bd <= 1'b0; m_valid <= 1'b0; m_held <= 1'b0;
            m_icnt <= '0; m_bcnt <= '0;
            started <= 1'b1;
        end else if (Flush) begin
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_pc <= FPC; m_exc <= 5'd0;
            m_bd <= 1'b0; m_valid <= 1'b0; m_held <= 1'b0;
            m_bcnt <= m_bcnt + 1'b1;
        end else if (!En) begin
            m_held <= m_valid;
            if (!m_valid) m_bcnt <= m_bcnt + 1'b1;
        end else begin
            m_instr <= InstrFD; m_pc4 <= PC4FD; m_pc <= PCFD; m_exc <= ExcCodeFD;
            m_bd <= BranchD; m_valid <= 1'b1; m_held <= 1'b0;
            m_icnt <= m_icnt + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (started) begin
            chk("model_InstrD", InstrD, m_instr);
            chk("model_PC4D", PC4D, m_pc4);
            chk("model_PCD", PCD, m_pc);
            chk("model_ExcCodeD", ExcCodeD, m_exc);
            chk("model_BDD", BDD, m_bd);
            chk("model_ValidD", ValidD, m_valid);
            chk("model_HeldD", HeldD, m_held);
`ifdef FD_PERF_CNT_EN
            chk("model_InstrCnt", InstrCnt, m_icnt);
            chk("model_BubbleCnt", BubbleCnt, m_bcnt);
`else
            chk("model_InstrCnt", InstrCnt, '0);
            chk("model_BubbleCnt", BubbleCnt, '0);
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic en, input logic fl, input logic br,
                         input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc);
        Reset = rst; En = en; Flush = fl; BranchD = br;
        PCFD = pc; PC4FD = pc + 32'd4; InstrFD = instr; ExcCodeFD = exc;
    endtask

    initial begin
        // Reset for two cycles.
        drive(1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCD", PCD, FPC);
        chk("rst_ValidD", ValidD, 1'b0);
        chk("rst_HeldD", HeldD, 1'b0);

        drive(0, 1, 0, 0, 32'h3000, 32'h2408_0001, 5'd0);
        tick();
        chk("first_PCD", PCD, 32'h3000);
        chk("first_PC4D", PC4D, 32'h3004);
        chk("first_ValidD", ValidD, 1'b1);
        chk("first_HeldD", HeldD, 1'b0);

        drive(0, 1, 0, 0, 32'h3008, 32'h2409_0002, 5'd0);
        tick();
        chk("load3008_PCD", PCD, 32'h3008);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 32'h4000 + 32'(i * 4), $urandom, 5'd0);
            tick();
            chk("stall_PCD", PCD, 32'h3008);
            chk("stall_InstrD", InstrD, 32'h2409_0002);
            chk("stall_HeldD", HeldD, 1'b1);
        end

        drive(0, 1, 0, 1, 32'h300c, 32'h1000_0003, 5'd0);
        tick();
        chk("resume_PCD", PCD, 32'h300c);
        chk("resume_HeldD", HeldD, 1'b0);
        chk("br_BDD", BDD, 1'b1);

        drive(0, 1, 0, 0, 32'h3010, 32'h0000_0000, 5'd0);
        tick();
        chk("nobr_BDD", BDD, 1'b0);
        drive(0, 0, 0, 1, 32'h3014, 32'h1111_1111, 5'd0);
        tick();
        chk("stallbr_BDD", BDD, 1'b0);
        chk("stallbr_PCD", PCD, 32'h3010);
        chk("stallbr_HeldD", HeldD, 1'b1);

        // Flush while stalled in HELD.
        drive(0, 0, 1, 1, 32'h3018, 32'h2222_2222, 5'd3);
        tick();
        chk("flush_InstrD", InstrD, 32'h0);
        chk("flush_ValidD", ValidD, 1'b0);
        chk("flush_PCD", PCD, FPC);
        chk("flush_BDD", BDD, 1'b0);

        drive(0, 1, 0, 0, 32'h3001, 32'h0, 5'd4);
        tick();
        chk("exc_ExcCodeD", ExcCodeD, 5'd4);
        chk("exc_ValidD", ValidD, 1'b1);
        chk("exc_InstrD", InstrD, 32'h0);
        chk("exc_PCD", PCD, 32'h3001);

        // Counter scenario: 5 loads, 2 stalls, 1 flush, 1 idle.
        drive(1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 32'h5000 + 32'(i * 4), $urandom, 5'd0);
            tick();
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0); tick(); tick();
        drive(0, 0, 1, 0, 32'h0, 32'h0, 5'd0); tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0); tick();
`ifdef FD_PERF_CNT_EN
        chk("cnt_InstrCnt", InstrCnt, 8'd5);
        chk("cnt_BubbleCnt", BubbleCnt, 8'd2);
`else
        chk("cnt_InstrCnt", InstrCnt, 8'd0);
        chk("cnt_BubbleCnt", BubbleCnt, 8'd0);
`endif

        // Randomized traffic, long enough for the 8-bit counters to wrap.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 65535)),
                  $urandom, 5'($urandom_range(0, 31)));
            tick();
        end

        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
